// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline encodings: ALU operations, writeback select, forwarding
// select and branch funct3 codes.
package riscv_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RD = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: one-cycle latency, synchronous active-low clear,
// no stall or enable.
module ex_mem
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: rtl/iexecute.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM register. Define IEXECUTE_BRANCH_STATS_EN to add branch counters.
module iexecute
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
`ifdef IEXECUTE_BRANCH_STATS_EN
   ,parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [2:0]      Funct3E,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
`ifdef IEXECUTE_BRANCH_STATS_EN
    output logic [CNT_W-1:0] BranchCountE,
    output logic [CNT_W-1:0] TakenCountE,
`endif
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [XLEN-1:0] WriteDataE;
    logic [XLEN-1:0] ALUResultE;
    logic            cond;

    // Forwarding from M reads the registered ALU result of the previous instruction.
    always_comb begin
        case (ForwardAE)
            FWD_W:   SrcAE = ResultW;
            FWD_M:   SrcAE = ALUResultM;
            default: SrcAE = RD1E;
        endcase
        case (ForwardBE)
            FWD_W:   WriteDataE = ResultW;
            FWD_M:   WriteDataE = ALUResultM;
            default: WriteDataE = RD2E;
        endcase
        SrcBE = ALUSrcE ? ImmExtE : WriteDataE;
    end

    always_comb begin
        case (ALUControlE)
            ALU_ADD: ALUResultE = SrcAE + SrcBE;
            ALU_SUB: ALUResultE = SrcAE - SrcBE;
            ALU_AND: ALUResultE = SrcAE & SrcBE;
            ALU_OR:  ALUResultE = SrcAE | SrcBE;
            ALU_XOR: ALUResultE = SrcAE ^ SrcBE;
            ALU_SLT: ALUResultE = {{(XLEN-1){1'b0}}, $signed(SrcAE) < $signed(SrcBE)};
            ALU_SLL: ALUResultE = SrcAE << SrcBE[4:0];
            default: ALUResultE = SrcAE >> SrcBE[4:0];
        endcase
    end

    // Branches compare the forwarded register operands, never the immediate.
    always_comb begin
        case (Funct3E)
            F3_BEQ:  cond = (SrcAE == WriteDataE);
            F3_BNE:  cond = (SrcAE != WriteDataE);
            F3_BLT:  cond = ($signed(SrcAE) < $signed(WriteDataE));
            F3_BGE:  cond = ($signed(SrcAE) >= $signed(WriteDataE));
            F3_BLTU: cond = (SrcAE < WriteDataE);
            F3_BGEU: cond = (SrcAE >= WriteDataE);
            default: cond = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | (BranchE & cond);
    assign PCTargetE = PCE + ImmExtE;

`ifdef IEXECUTE_BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            BranchCountE <= '0;
            TakenCountE  <= '0;
        end else begin
            if (BranchE)
                BranchCountE <= BranchCountE + CNT_W'(1);
            if (BranchE & cond)
                TakenCountE <= TakenCountE + CNT_W'(1);
        end
    end
`endif

    ex_mem #(
        .XLEN(XLEN)
    ) u_ex_mem (
        .clk        (clk),
        .reset      (reset),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .RdE        (RdE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .PCPlus4E   (PCPlus4E),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M)
    );

endmodule

// File: tb/tb_iexecute.sv
// Self-checking bench for iexecute: directed scenarios plus randomized cycles
// against an arithmetic reference model. Honours IEXECUTE_BRANCH_STATS_EN.
module tb_iexecute;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE, Funct3E;
    logic [4:0]  RdE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
`ifdef IEXECUTE_BRANCH_STATS_EN
    logic [31:0] BranchCountE, TakenCountE;
    logic [31:0] m_bcnt, m_tcnt;
`endif

    // Model of the EX/MEM register contents
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    iexecute #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .Funct3E     (Funct3E),
        .RdE         (RdE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .PCE         (PCE),
        .ImmExtE     (ImmExtE),
        .PCPlus4E    (PCPlus4E),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
`ifdef IEXECUTE_BRANCH_STATS_EN
        .BranchCountE(BranchCountE),
        .TakenCountE (TakenCountE),
`endif
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RdM         (RdM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rd);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu;
        return rd;
    endfunction

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (op)
            0: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            1: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sa < sb) ? 32'd1 : 32'd0;
            6: return 32'(longint'(a) * (64'd1 << sh));
            default: return 32'(longint'(a) / (64'd1 << sh));
        endcase
    endfunction

    function automatic logic cond_ref(input int f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f3)
            0: return ua == ub;
            1: return ua != ub;
            4: return sa < sb;
            5: return sa >= sb;
            6: return ua < ub;
            7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Inputs must be stable before calling; checks combinational outputs, then the
    // registered outputs #1 after the next rising edge.
    task automatic cycle();
        logic [31:0] a, wd, b, res;
        logic        c;
        a   = fwd_ref(ForwardAE, RD1E);
        wd  = fwd_ref(ForwardBE, RD2E);
        b   = ALUSrcE ? ImmExtE : wd;
        res = alu_ref(int'(ALUControlE), a, b);
        c   = cond_ref(int'(Funct3E), a, wd);
        #1;
        check("pcsrc", {31'd0, PCSrcE}, {31'd0, JumpE | (BranchE & c)});
        check("pctarget", PCTargetE, 32'((longint'(PCE) + longint'(ImmExtE)) % 64'h1_0000_0000));
        @(posedge clk);
        if (!reset) begin
            m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
`ifdef IEXECUTE_BRANCH_STATS_EN
            m_bcnt = 0; m_tcnt = 0;
`endif
        end else begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RdE;
            m_alu = res; m_wd = wd; m_pc4 = PCPlus4E;
`ifdef IEXECUTE_BRANCH_STATS_EN
            if (BranchE) m_bcnt = m_bcnt + 1;
            if (BranchE && c) m_tcnt = m_tcnt + 1;
`endif
        end
        #1;
        check("regwritem", {31'd0, RegWriteM}, {31'd0, m_rw});
        check("memwritem", {31'd0, MemWriteM}, {31'd0, m_mw});
        check("resultsrcm", {30'd0, ResultSrcM}, {30'd0, m_rs});
        check("rdm", {27'd0, RdM}, {27'd0, m_rd});
        check("aluresultm", ALUResultM, m_alu);
        check("writedatam", WriteDataM, m_wd);
        check("pcplus4m", PCPlus4M, m_pc4);
`ifdef IEXECUTE_BRANCH_STATS_EN
        check("branchcount", BranchCountE, m_bcnt);
        check("takencount", TakenCountE, m_tcnt);
`endif
    endtask

    task automatic randomize_inputs();
        RegWriteE   = 1'($urandom);
        MemWriteE   = 1'($urandom);
        JumpE       = ($urandom_range(0, 7) == 0);
        BranchE     = 1'($urandom);
        ALUSrcE     = 1'($urandom);
        ResultSrcE  = 2'($urandom_range(0, 2));
        ALUControlE = 3'($urandom);
        Funct3E     = 3'($urandom);
        RdE         = 5'($urandom);
        RD1E        = $urandom;
        RD2E        = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        PCE         = $urandom;
        ImmExtE     = $urandom;
        PCPlus4E    = $urandom;
        ResultW     = $urandom;
        ForwardAE   = 2'($urandom);
        ForwardBE   = 2'($urandom);
    endtask

    task automatic clear_inputs();
        {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE} = '0;
        ResultSrcE = '0; ALUControlE = '0; Funct3E = 3'd2; RdE = '0;
        RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0; ResultW = '0;
        ForwardAE = '0; ForwardBE = '0;
    endtask

    initial begin
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
`ifdef IEXECUTE_BRANCH_STATS_EN
        m_bcnt = 0; m_tcnt = 0;
`endif
        // Reset with busy, non-zero inputs
        reset = 1'b0;
        randomize_inputs();
        RegWriteE = 1; MemWriteE = 1; RdE = 5'd9; ForwardAE = 0; ForwardBE = 0;
        @(posedge clk); #1;
        cycle();
        cycle();
        check("reset_alu_zero", ALUResultM, 32'd0);
        check("reset_rd_zero", {27'd0, RdM}, 32'd0);
        reset = 1'b1;
        cycle();
        check("release_rd", {27'd0, RdM}, 32'd9);

        // Subtraction and wrap
        clear_inputs();
        RD1E = 7; RD2E = 5; ALUControlE = 3'b001;
        cycle();
        check("sub_7_5", ALUResultM, 32'd2);
        RD1E = 5; RD2E = 7;
        cycle();
        check("sub_5_7", ALUResultM, 32'hFFFF_FFFE);

        // Forwarding from W, then from M
        clear_inputs();
        RD1E = 1; ResultW = 10; ForwardAE = 2'b01; ImmExtE = 3; ALUSrcE = 1;
        cycle();
        check("fwd_w_add", ALUResultM, 32'd13);
        clear_inputs();
        ForwardBE = 2'b10;
        cycle();
        check("fwd_m_wd", WriteDataM, 32'd13);

        // Branches; counters start from a fresh reset
        clear_inputs();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        BranchE = 1; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        RD1E = 32'hFFFF_FFFF; RD2E = 1; Funct3E = 3'b100;
        #1;
        check("blt_taken", {31'd0, PCSrcE}, 32'd1);
        check("blt_target", PCTargetE, 32'h0000_00F8);
        cycle();
        Funct3E = 3'b110;
        #1;
        check("bltu_not_taken", {31'd0, PCSrcE}, 32'd0);
        cycle();
        Funct3E = 3'b000; RD2E = 32'hFFFF_FFFF;
        cycle();

        // jal
        clear_inputs();
        JumpE = 1; RegWriteE = 1; ResultSrcE = 2'b10; PCPlus4E = 32'h104; RdE = 5'd1;
        #1;
        check("jal_pcsrc", {31'd0, PCSrcE}, 32'd1);
        cycle();
        check("jal_resultsrcm", {30'd0, ResultSrcM}, 32'd2);
        check("jal_pcplus4m", PCPlus4M, 32'h104);
`ifdef IEXECUTE_BRANCH_STATS_EN
        check("stats_branches", BranchCountE, 32'd3);
        check("stats_taken", TakenCountE, 32'd2);
        clear_inputs();
        reset = 1'b0;
        cycle();
        check("stats_branches_rst", BranchCountE, 32'd0);
        check("stats_taken_rst", TakenCountE, 32'd0);
        reset = 1'b1;
`endif

        // Randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 24) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iexecute.md
Name: iexecute

Overview:
- Execute stage of the 5-stage RV32I pipeline; consumes the ID/EX register outputs of the decode stage.
- Applies hazard-unit forwarding to both operands, runs the ALU, resolves branches and jumps, and computes the branch/jump target.
- Drives PCSrcE/PCTargetE back to fetch and owns the EX/MEM pipeline register feeding the memory stage.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the branch statistics counters (only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1  control from ID/EX.
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- Funct3E  in  3  branch condition; ID/EX extended to carry it.
- RdE  in  5  destination register.
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  XLEN  ID/EX data.
- ForwardAE, ForwardBE  in  2  00 RD, 01 ResultW, 10 ALUResultM.
- ResultW  in  XLEN  writeback result.
- PCSrcE  out  1  redirect fetch; combinational.
- PCTargetE  out  XLEN  PCE + ImmExtE; combinational.
- RegWriteM, MemWriteM  out  1  EX/MEM control.
- ResultSrcM  out  2  EX/MEM result select.
- RdM  out  5  EX/MEM destination register.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  EX/MEM data.

Behaviour:
- SrcAE = mux(ForwardAE: RD1E, ResultW, ALUResultM). ForwardAE = 11 selects RD1E.
- WriteDataE = the same mux on ForwardBE/RD2E. ForwardBE = 11 selects RD2E.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALUResultM is registered; the forwarding path reads the current register output.
- ALU:
  - add/sub wrap modulo 2^XLEN.
  - slt is a signed compare with a zero-extended 1-bit result.
  - sll/srl use SrcBE[4:0].
- Branch compare on SrcAE vs WriteDataE, using the forwarded operands, never SrcBE:
  - Funct3 000 beq, 001 bne, 100 blt, 101 bge (signed).
  - Funct3 110 bltu, 111 bgeu (unsigned).
  - Funct3 010 and 011 mean not taken.
- PCSrcE = JumpE | (BranchE & cond).
- PCTargetE = PCE + ImmExtE, wrapping modulo 2^XLEN. jalr targets are out of scope.
- EX/MEM register, updated every rising clk edge:
  - reset low: all M outputs clear to 0 on that edge.
  - reset high: M outputs capture the current E values.
  - Latency is 1 cycle, with no stall or enable.
  - A bubble arrives as zeroed control from ID/EX and passes through unchanged.
- Reset asserted mid-operation clears the M outputs on that edge. PCSrcE and PCTargetE remain combinational functions of their inputs.
- Jump or branch taken with RegWriteE = 1 (jal): the ALU result is still registered. ResultSrcE = 10 makes writeback select PCPlus4M.

Optional Feature:
- Macro: IEXECUTE_BRANCH_STATS_EN.
- When defined, adds two outputs, BranchCountE and TakenCountE, each CNT_W wide and registered.
  - BranchCountE increments on each cycle with BranchE = 1.
  - TakenCountE increments on each cycle with BranchE & cond.
  - Both counters clear on reset and wrap to 0 after all-ones.
  - Jumps are not counted.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package riscv_pkg holds:
  - ALUControl encodings (ALU_ADD ... ALU_SRL).
  - ResultSrc encodings.
  - Forward encodings (FWD_RD, FWD_W, FWD_M).
  - Funct3 branch codes.
- Natural sub-module: ex_mem, the EX/MEM pipeline register, matching the existing id_ex style.
- The ALU stays as a combinational function or block inside iexecute.

Test Plan:
- Reset low for 2 clk with non-zero E inputs -> all M outputs 0. Release -> next edge captures E values.
- RD1E = 7, RD2E = 5, ALUControlE = 001, ALUSrcE = 0, Forward = 00 -> ALUResultM = 2 one cycle later. RD1E = 5, RD2E = 7 -> 0xFFFFFFFE.
- Forwarding: RD1E = 1, ResultW = 10, ForwardAE = 01, ImmExtE = 3, ALUSrcE = 1, add -> 13. Next cycle ForwardBE = 10 -> WriteDataM = 13.
- Branch compares, all with BranchE = 1, PCE = 0x100, ImmExtE = -8:
  - blt, RD1E = 0xFFFFFFFF, RD2E = 1 -> PCSrcE = 1, PCTargetE = 0xF8.
  - bltu on the same operands -> PCSrcE = 0.
- jal: JumpE = 1, ResultSrcE = 10, PCPlus4E = 0x104 -> PCSrcE = 1 same cycle. Next cycle ResultSrcM = 10, PCPlus4M = 0x104.
- With IEXECUTE_BRANCH_STATS_EN: 3 branches (2 taken) plus 1 jump -> BranchCountE = 3, TakenCountE = 2. Reset -> both 0.
